// File: rtl/seq_pkg.sv
// Shared types and field constants for the fetch/sequence controller.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } seq_state_e;

  localparam int PC_W    = 4;
  localparam int INSTR_W = 16;
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  localparam logic [OPC_MSB-OPC_LSB:0] HALT_OP_DEFAULT = 4'b1111;

endpackage

// File: rtl/pc_sequencer.sv
// Program counter and run/step/halt sequencing for the single-cycle datapath.
// exec_en qualifies every datapath state write for the instruction at pc.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter logic [OPC_MSB-OPC_LSB:0] HALT_OP   = HALT_OP_DEFAULT,
  parameter bit                       WRAP_HALT = 1'b0,
  parameter int                       CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               step,
  input  logic               stop,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch_take,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic               exec_en,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   icount
);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [CNT_W-1:0]   icount_q, icount_d;
  logic               active;
  logic               hop;
  logic               instr_unused;

  assign instr_unused = ^instr[OPC_LSB-1:0];

  assign active  = (state_q == RUN) || (state_q == STEP);
  assign hop     = active && (instr[OPC_MSB:OPC_LSB] == HALT_OP);
  assign exec_en = active && !hop && !clear;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    icount_d = icount_q;
    if (clear) begin
      state_d  = IDLE;
      pc_d     = '0;
      icount_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start)     state_d = RUN;
          else if (step) state_d = STEP;
        end
        RUN, STEP: begin
          if (hop) begin
            state_d = HALTED;
          end else begin
            pc_d = branch_take ? branch_target : pc_q + PC_W'(1);
            if (icount_q != {CNT_W{1'b1}}) icount_d = icount_q + CNT_W'(1);
            // Falling off the end of memory halts only when no branch redirects fetch.
            if (WRAP_HALT && (pc_q == {PC_W{1'b1}}) && !branch_take)
              state_d = HALTED;
            else if ((state_q == STEP) || stop)
              state_d = IDLE;
          end
        end
        HALTED: state_d = HALTED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
    end
  end

  assign pc     = pc_q;
  assign icount = icount_q;
  assign busy   = active;
  assign halted = (state_q == HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (wrap / halt-at-end) against a cycle model.
module tb_pc_sequencer;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] pc;
    logic [7:0] ic;
  } mst_t;

  typedef struct packed {
    logic       id;
    logic [3:0] pc;
    logic       ex;
    logic       busy;
    logic       halted;
    logic [7:0] ic;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, step, stop, clear, branch_take;
  logic [3:0]  branch_target;
  logic [15:0] mem [16];
  logic [15:0] instr0, instr1;
  logic [3:0]  pc0, pc1;
  logic        ex0, ex1, busy0, busy1, halted0, halted1;
  logic [7:0]  ic0, ic1;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  mst_t ms[2];
  mst_t nx[2];

  always #5 clk = ~clk;

  assign instr0 = mem[pc0];
  assign instr1 = mem[pc1];

  pc_sequencer #(.HALT_OP(4'hF), .WRAP_HALT(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop), .clear(clear),
    .instr(instr0), .branch_take(branch_take), .branch_target(branch_target),
    .pc(pc0), .exec_en(ex0), .busy(busy0), .halted(halted0), .icount(ic0)
  );

  pc_sequencer #(.HALT_OP(4'hF), .WRAP_HALT(1'b1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .step(step), .stop(stop), .clear(clear),
    .instr(instr1), .branch_take(branch_take), .branch_target(branch_target),
    .pc(pc1), .exec_en(ex1), .busy(busy1), .halted(halted1), .icount(ic1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one sequencer for one clock cycle.
  function automatic void mstep(input mst_t s, input bit wrap, input logic [15:0] ins,
                                input logic st, input logic sp, input logic so,
                                input logic cl, input logic bt, input logic [3:0] tg,
                                output exp_t e, output mst_t n);
    bit act, halt_op;
    act       = (s.st == 2'd1) || (s.st == 2'd2);
    halt_op   = act && (ins[15:12] == 4'hF);
    e.id      = wrap;
    e.pc      = s.pc;
    e.ex      = act && !halt_op && !cl;
    e.busy    = act;
    e.halted  = (s.st == 2'd3);
    e.ic      = s.ic;
    n = s;
    if (cl) begin
      n = '0;
    end else if (halt_op) begin
      n.st = 2'd3;
    end else if (e.ex) begin
      n.pc = bt ? tg : s.pc + 4'd1;
      if (s.ic != 8'hFF) n.ic = s.ic + 8'd1;
      if (wrap && s.pc == 4'd15 && !bt) n.st = 2'd3;
      else if (s.st == 2'd2 || so)      n.st = 2'd0;
    end else if (s.st == 2'd0) begin
      n.st = st ? 2'd1 : (sp ? 2'd2 : 2'd0);
    end
  endfunction

  task automatic cyc(input logic st = 0, input logic sp = 0, input logic so = 0,
                     input logic cl = 0, input logic bt = 0, input logic [3:0] tg = 0);
    exp_t e;
    @(negedge clk);
    start = st; step = sp; stop = so; clear = cl; branch_take = bt; branch_target = tg;
    for (int d = 0; d < 2; d++) begin
      mstep(ms[d], d == 1, mem[ms[d].pc], st, sp, so, cl, bt, tg, e, nx[d]);
      q.push_back(e);
    end
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("d%0d.pc", e.id),     e.id ? pc1 : pc0,         e.pc);
      chk($sformatf("d%0d.exec", e.id),   e.id ? ex1 : ex0,         e.ex);
      chk($sformatf("d%0d.busy", e.id),   e.id ? busy1 : busy0,     e.busy);
      chk($sformatf("d%0d.halted", e.id), e.id ? halted1 : halted0, e.halted);
      chk($sformatf("d%0d.icount", e.id), e.id ? ic1 : ic0,         e.ic);
    end
    @(posedge clk);
    ms[0] = nx[0];
    ms[1] = nx[1];
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; step = 0; stop = 0; clear = 0; branch_take = 0; branch_target = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    ms[0] = '0;
    ms[1] = '0;
    #2;
    chk("rst.pc", pc0, 0);
    chk("rst.exec", ex0, 0);
    chk("rst.busy", busy0, 0);
    chk("rst.halted", halted0, 0);
    chk("rst.icount", ic0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Short program ending in a halt opcode.
    mem[0] = 16'hA00A; mem[1] = 16'h5005; mem[2] = 16'h6006;
    mem[3] = 16'h0A50; mem[4] = 16'h06A0; mem[5] = 16'hF000;
    cyc(1);
    for (int i = 0; i < 6; i++) cyc();
    chk("prog.halted", halted0, 1);
    chk("prog.icount", ic0, 5);
    chk("prog.pc", pc0, 5);
    cyc(0, 0, 0, 0, 1, 4'd9);
    cyc(1, 1);
    chk("halt.ignore_pc", pc0, 5);
    chk("halt.ignore_st", halted0, 1);
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    cyc(0, 0, 0, 1);

    // Single step, then held step.
    cyc(0, 1);
    cyc();
    chk("step.pc", pc0, 1);
    chk("step.icount", ic0, 1);
    chk("step.busy", busy0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1);
    chk("hstep.pc", pc0, 3);

    // Branch while running, then stop on a normal instruction.
    cyc(1, 0, 0, 0, 1, 4'd9);
    cyc(0, 0, 0, 0, 1, 4'd9);
    chk("branch.pc", pc0, 9);
    cyc(0, 0, 1);
    chk("stop.pc", pc0, 10);
    chk("stop.busy", busy0, 0);

    // Stop coinciding with a halt opcode.
    mem[10] = 16'hF000;
    cyc(1);
    cyc(0, 0, 1);
    chk("stophalt.halted", halted0, 1);
    mem[10] = 16'h0000;
    cyc(0, 0, 0, 1);

    // Clear while running at pc=7.
    cyc(1);
    for (int i = 0; i < 7; i++) cyc();
    chk("clr.pre_pc", pc0, 7);
    cyc(0, 0, 0, 1);
    chk("clr.pc", pc0, 0);
    chk("clr.icount", ic0, 0);
    chk("clr.busy", busy0, 0);

    // Asynchronous reset between clock edges.
    cyc(1);
    for (int i = 0; i < 3; i++) cyc();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.pc", pc0, 0);
    chk("arst.exec", ex0, 0);
    chk("arst.busy", busy0, 0);
    chk("arst.icount", ic0, 0);
    ms[0] = '0;
    ms[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero program: wrap and saturation vs halt at end of memory.
    cyc(1);
    for (int i = 0; i < 300; i++) cyc();
    chk("wrap.icount_sat", ic0, 8'hFF);
    chk("wrap.pc", pc0, 12);
    chk("wrap.busy", busy0, 1);
    chk("end.halted", halted1, 1);
    chk("end.pc", pc1, 0);
    chk("end.icount", ic1, 16);

    // Taken branch at pc=15 does not halt.
    cyc(0, 0, 0, 1);
    cyc(1);
    for (int i = 0; i < 15; i++) cyc();
    chk("br15.pre_pc", pc1, 15);
    cyc(0, 0, 0, 0, 1, 4'd2);
    chk("br15.halted", halted1, 0);
    chk("br15.pc", pc1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
